memory_round_ctrl: RTL and testbench

Parametrised round controller for the LED/button pattern-memory game. It replaces the hard-wired 8-LED / 16-step / 16-round flow with a single-clock FSM that does the following: accepts a one-hot level, generates a random pattern, plays it on the LEDs, captures and checks button entries, and keeps round and score counts until the game ends. Upstream is the level-select/keypad block; downstream are the 7-segment score display and the LED drivers.

---
 rtl/mem_game_pkg.sv | 39 +++
 rtl/memory_round_ctrl_lfsr16.sv | 27 ++
 rtl/memory_round_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_memory_round_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_game_pkg.sv
// Shared definitions for the pattern-memory game round controller.
//   state_t        : round controller FSM states
//   LVL_*          : one-hot level encodings from the level-select block
//   len_for_level  : pattern length for a one-hot level
//   onehot_valid   : true when exactly one bit of a 16-bit vector is set
package mem_game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GEN      = 3'd1,
      ST_SHOW_ON  = 3'd2,
      ST_SHOW_OFF = 3'd3,
      ST_INPUT    = 3'd4,
      ST_JUDGE    = 3'd5,
      ST_GAP      = 3'd6,
      ST_DONE     = 3'd7
   } state_t;

   localparam logic [2:0] LVL_1 = 3'b001;
   localparam logic [2:0] LVL_2 = 3'b010;
   localparam logic [2:0] LVL_3 = 3'b100;

   // Level 1 plays a quarter of the full pattern, level 2 half, level 3 all.
   function automatic int len_for_level(input logic [2:0] level, input int max_len);
      int len;
      case (level)
         LVL_1:   len = max_len / 4;
         LVL_2:   len = max_len / 2;
         LVL_3:   len = max_len;
         default: len = 0;
      endcase
      return len;
   endfunction

   function automatic logic onehot_valid(input logic [15:0] v);
      return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
   endfunction

endpackage

// File: rtl/memory_round_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR (taps 16,14,13,11), stepping every cycle.
//   clk  : clock
//   rst  : active-low synchronous reset, loads SEED
//   rnd  : low OUT_W bits of the LFSR state
module lfsr16 #(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int          OUT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   output logic [OUT_W-1:0] rnd
);

   logic [15:0] lfsr_r;

   // LFSR state: right-shifting Galois form, feedback mask 0xB400.
   always_ff @(posedge clk) begin
      if (!rst) begin
         lfsr_r <= SEED;
      end else begin
         lfsr_r <= {1'b0, lfsr_r[15:1]} ^ ({16{lfsr_r[0]}} & 16'hB400);
      end
   end

   assign rnd = lfsr_r[OUT_W-1:0];

endmodule

// File: rtl/memory_round_ctrl.sv
// Round controller for the LED/button pattern-memory game.
// Generates a random pattern, plays it on the LEDs, checks button entries
// and keeps round/score counts until N_ROUNDS rounds have been played.
//   clk, rst        : clock, active-low synchronous reset
//   level, start    : one-hot level, sampled on the start pulse in IDLE/DONE
//   btn             : debounced single-cycle press pulses
//   led             : pattern playback / press echo
//   busy            : game in progress (not IDLE/DONE)
//   input_phase     : entries are accepted
//   round_win/lose  : one-cycle round result pulses
//   round_cnt/score : completed rounds / rounds won
//   game_end        : high in DONE
//   level_err       : one-cycle pulse on start with a non-one-hot level
module memory_round_ctrl
   import mem_game_pkg::*;
#(
   parameter int          N_BTN       = 8,
   parameter int          MAX_LEN     = 16,
   parameter int          N_ROUNDS    = 10,
   parameter int          ON_CYC      = 4,
   parameter int          OFF_CYC     = 2,
   parameter int          GAP_CYC     = 8,
   parameter int          TIMEOUT_CYC = 1024,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       level,
   input  logic             start,
   input  logic [N_BTN-1:0] btn,
   output logic [N_BTN-1:0] led,
   output logic             busy,
   output logic             input_phase,
   output logic             round_win,
   output logic             round_lose,
   output logic [4:0]       round_cnt,
   output logic [4:0]       score,
   output logic             game_end,
   output logic             level_err
);

   localparam int IDX_W   = $clog2(N_BTN);
   localparam int PTR_W   = $clog2(MAX_LEN);
   localparam int T_A     = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int T_B     = (T_A > GAP_CYC) ? T_A : GAP_CYC;
   localparam int TMR_MAX = (T_B > TIMEOUT_CYC) ? T_B : TIMEOUT_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   state_t             state_r, state_nxt_s;
   logic [PTR_W-1:0]   idx_r, idx_nxt_s;
   logic [PTR_W-1:0]   last_r, last_nxt_s;
   logic [TMR_W-1:0]   tmr_r, tmr_nxt_s;
   logic [4:0]         rc_nxt_s, sc_nxt_s;
   logic               win_nxt_s, lose_nxt_s, lerr_nxt_s;
   logic               wr_en_s;
   logic [IDX_W-1:0]   rnd_s;
   logic [N_BTN-1:0]   exp_btn_s;
   logic [N_BTN-1:0]   led_nxt_s;
   logic [IDX_W-1:0]   pat_r [MAX_LEN];

   lfsr16 #(
      .SEED  (SEED),
      .OUT_W (IDX_W)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .rnd (rnd_s)
   );

   // The single button pattern that counts as the correct next entry.
   assign exp_btn_s = {{(N_BTN-1){1'b0}}, 1'b1} << pat_r[idx_r];

   // Next-state, index, timer and counter logic.
   // One timer serves the ON/OFF/GAP phases and the input timeout; it only
   // advances on idle input cycles, so a press always beats a timeout.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      last_nxt_s  = last_r;
      tmr_nxt_s   = tmr_r;
      rc_nxt_s    = round_cnt;
      sc_nxt_s    = score;
      win_nxt_s   = 1'b0;
      lose_nxt_s  = 1'b0;
      lerr_nxt_s  = 1'b0;
      wr_en_s     = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               if (onehot_valid(16'(level))) begin
                  rc_nxt_s    = 5'd0;
                  sc_nxt_s    = 5'd0;
                  last_nxt_s  = PTR_W'(len_for_level(level, MAX_LEN) - 1);
                  idx_nxt_s   = {PTR_W{1'b0}};
                  state_nxt_s = ST_GEN;
               end else begin
                  lerr_nxt_s  = 1'b1;
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_GEN: begin
            wr_en_s = 1'b1;
            if (idx_r == last_r) begin
               idx_nxt_s   = {PTR_W{1'b0}};
               tmr_nxt_s   = {TMR_W{1'b0}};
               state_nxt_s = ST_SHOW_ON;
            end else begin
               idx_nxt_s   = idx_r + PTR_W'(1);
            end
         end
         ST_SHOW_ON: begin
            if (tmr_r == TMR_W'(ON_CYC - 1)) begin
               tmr_nxt_s   = {TMR_W{1'b0}};
               state_nxt_s = ST_SHOW_OFF;
            end else begin
               tmr_nxt_s   = tmr_r + TMR_W'(1);
            end
         end
         ST_SHOW_OFF: begin
            if (tmr_r == TMR_W'(OFF_CYC - 1)) begin
               tmr_nxt_s = {TMR_W{1'b0}};
               if (idx_r == last_r) begin
                  idx_nxt_s   = {PTR_W{1'b0}};
                  state_nxt_s = ST_INPUT;
               end else begin
                  idx_nxt_s   = idx_r + PTR_W'(1);
                  state_nxt_s = ST_SHOW_ON;
               end
            end else begin
               tmr_nxt_s = tmr_r + TMR_W'(1);
            end
         end
         ST_INPUT: begin
            if (btn == {N_BTN{1'b0}}) begin
               if (tmr_r == TMR_W'(TIMEOUT_CYC - 1)) begin
                  lose_nxt_s  = 1'b1;
                  rc_nxt_s    = round_cnt + 5'd1;
                  state_nxt_s = ST_JUDGE;
               end else begin
                  tmr_nxt_s   = tmr_r + TMR_W'(1);
               end
            end else if (btn == exp_btn_s) begin
               tmr_nxt_s = {TMR_W{1'b0}};
               if (idx_r == last_r) begin
                  win_nxt_s   = 1'b1;
                  rc_nxt_s    = round_cnt + 5'd1;
                  sc_nxt_s    = score + 5'd1;
                  state_nxt_s = ST_JUDGE;
               end else begin
                  idx_nxt_s   = idx_r + PTR_W'(1);
               end
            end else begin
               lose_nxt_s  = 1'b1;
               rc_nxt_s    = round_cnt + 5'd1;
               state_nxt_s = ST_JUDGE;
            end
         end
         ST_JUDGE: begin
            // Counters were updated on entry, so round_cnt is already the new count.
            tmr_nxt_s = {TMR_W{1'b0}};
            if (round_cnt == 5'(N_ROUNDS)) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_GAP;
            end
         end
         ST_GAP: begin
            if (tmr_r == TMR_W'(GAP_CYC - 1)) begin
               tmr_nxt_s   = {TMR_W{1'b0}};
               idx_nxt_s   = {PTR_W{1'b0}};
               state_nxt_s = ST_GEN;
            end else begin
               tmr_nxt_s   = tmr_r + TMR_W'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // LED value for the state being entered; input echo is one cycle late.
   always_comb begin
      led_nxt_s = {N_BTN{1'b0}};
      case (state_nxt_s)
         ST_SHOW_ON: led_nxt_s = {{(N_BTN-1){1'b0}}, 1'b1} << pat_r[idx_nxt_s];
         ST_INPUT:   led_nxt_s = (state_r == ST_INPUT) ? btn : {N_BTN{1'b0}};
         default:    led_nxt_s = {N_BTN{1'b0}};
      endcase
   end

   // Pattern RAM: written only during GEN, never reset since GEN rewrites it.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         pat_r[idx_r] <= rnd_s;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         idx_r       <= {PTR_W{1'b0}};
         last_r      <= {PTR_W{1'b0}};
         tmr_r       <= {TMR_W{1'b0}};
         round_cnt   <= 5'd0;
         score       <= 5'd0;
         led         <= {N_BTN{1'b0}};
         busy        <= 1'b0;
         input_phase <= 1'b0;
         round_win   <= 1'b0;
         round_lose  <= 1'b0;
         game_end    <= 1'b0;
         level_err   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         idx_r       <= idx_nxt_s;
         last_r      <= last_nxt_s;
         tmr_r       <= tmr_nxt_s;
         round_cnt   <= rc_nxt_s;
         score       <= sc_nxt_s;
         led         <= led_nxt_s;
         busy        <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
         input_phase <= (state_nxt_s == ST_INPUT);
         round_win   <= win_nxt_s;
         round_lose  <= lose_nxt_s;
         game_end    <= (state_nxt_s == ST_DONE);
         level_err   <= lerr_nxt_s;
      end
   end

endmodule

// File: tb/tb_memory_round_ctrl.sv
// Scoreboard bench for memory_round_ctrl: stimulus pushes expected pulses and
// expected per-cycle output values; a negedge monitor pops and compares.
module tb_memory_round_ctrl;

   localparam int          N_BTN       = 8;
   localparam int          MAX_LEN     = 16;
   localparam int          N_ROUNDS    = 3;
   localparam int          ON_CYC      = 4;
   localparam int          OFF_CYC     = 2;
   localparam int          GAP_CYC     = 8;
   localparam int          TIMEOUT_CYC = 1024;
   localparam logic [15:0] SEED        = 16'hACE1;

   localparam logic [2:0] K_WIN  = 3'b100;
   localparam logic [2:0] K_LOSE = 3'b010;
   localparam logic [2:0] K_LERR = 3'b001;

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       level;
   logic             start;
   logic [N_BTN-1:0] btn;
   logic [N_BTN-1:0] led;
   logic             busy, input_phase, round_win, round_lose, game_end, level_err;
   logic [4:0]       round_cnt, score;

   memory_round_ctrl #(
      .N_BTN(N_BTN), .MAX_LEN(MAX_LEN), .N_ROUNDS(N_ROUNDS), .ON_CYC(ON_CYC),
      .OFF_CYC(OFF_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .level(level), .start(start), .btn(btn), .led(led),
      .busy(busy), .input_phase(input_phase), .round_win(round_win),
      .round_lose(round_lose), .round_cnt(round_cnt), .score(score),
      .game_end(game_end), .level_err(level_err)
   );

   always #5 clk = ~clk;

   // Reference LFSR and per-cycle history; hist[k] is the LFSR value during cycle k.
   int          cyc = 0;
   logic [15:0] lfsr_m = SEED;
   logic [15:0] hist [0:65535];

   function automatic logic [15:0] lstep(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   always @(posedge clk) begin
      cyc          <= cyc + 1;
      lfsr_m       <= rst ? lstep(lfsr_m) : SEED;
      hist[cyc+1]  <= rst ? lstep(lfsr_m) : SEED;
   end

   typedef struct { int cyc; int sel; logic [15:0] val; } obs_t;
   typedef struct { int cyc; logic [2:0] kind; logic [4:0] rc; logic [4:0] sc; } ev_t;
   obs_t  obs_q[$];
   ev_t   ev_q[$];
   int    checks = 0;
   int    failures = 0;
   string nm [6] = '{"led", "busy", "input_phase", "game_end", "round_cnt", "score"};

   function automatic logic [15:0] dut_sig(input int sel);
      case (sel)
         0:       return {8'd0, led};
         1:       return {15'd0, busy};
         2:       return {15'd0, input_phase};
         3:       return {15'd0, game_end};
         4:       return {11'd0, round_cnt};
         5:       return {11'd0, score};
         default: return 16'hFFFF;
      endcase
   endfunction

   // Pattern entry i of the round whose GEN phase starts at cycle b+1.
   function automatic logic [2:0] pat(input int b, input int i);
      logic [15:0] h;
      h = hist[b + 1 + i];
      return h[2:0];
   endfunction

   function automatic logic [7:0] oh(input logic [2:0] p);
      logic [7:0] one;
      one = 8'd1;
      return one << p;
   endfunction

   task automatic expect_obs(input int c, input int sel, input logic [15:0] v);
      obs_t o;
      o.cyc = c; o.sel = sel; o.val = v;
      obs_q.push_back(o);
   endtask

   task automatic expect_ev(input int c, input logic [2:0] k, input logic [4:0] rc, input logic [4:0] sc);
      ev_t e;
      e.cyc = c; e.kind = k; e.rc = rc; e.sc = sc;
      ev_q.push_back(e);
   endtask

   // Monitor: result pulses pop the event queue; counters are checked a cycle later.
   ev_t pend_e;
   bit  pend = 1'b0;
   always @(negedge clk) begin
      logic [2:0] act;
      if (pend) begin
         checks++;
         if (round_cnt !== pend_e.rc || score !== pend_e.sc) begin
            failures++;
            $display("FAIL counters cyc=%0d round_cnt=%0d score=%0d required %0d/%0d",
                     cyc, round_cnt, score, pend_e.rc, pend_e.sc);
         end
         pend = 1'b0;
      end
      act = {round_win, round_lose, level_err};
      if (act != 3'b000) begin
         checks++;
         if (ev_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse cyc=%0d pulses=%b required none", cyc, act);
         end else begin
            pend_e = ev_q.pop_front();
            pend   = 1'b1;
            if (act !== pend_e.kind || cyc != pend_e.cyc) begin
               failures++;
               $display("FAIL pulse cyc=%0d pulses=%b required cyc=%0d pulses=%b",
                        cyc, act, pend_e.cyc, pend_e.kind);
            end
         end
      end
      for (int i = obs_q.size() - 1; i >= 0; i--) begin
         if (obs_q[i].cyc <= cyc) begin
            checks++;
            if (obs_q[i].cyc < cyc || dut_sig(obs_q[i].sel) !== obs_q[i].val) begin
               failures++;
               $display("FAIL %s cyc=%0d got=%0h required=%0h at cyc %0d",
                        nm[obs_q[i].sel], cyc, dut_sig(obs_q[i].sel), obs_q[i].val, obs_q[i].cyc);
            end
            obs_q.delete(i);
         end
      end
   end

   task automatic wait_cyc(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic press(input int k, input logic [7:0] v);
      wait_cyc(k);
      btn = v;
      @(negedge clk);
      btn = 8'd0;
   endtask

   task automatic start_game(input logic [2:0] lv, output int b);
      level = lv;
      start = 1'b1;
      b     = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Expected GEN/playback behaviour; returns the first INPUT cycle.
   task automatic show_round(input int b, input int len, output int in_c);
      expect_obs(b + 2, 1, 16'd1);
      expect_obs(b + len, 0, 16'd0);
      wait_cyc(b + len);
      for (int s = 0; s < len; s++) begin
         for (int t = 0; t < ON_CYC + OFF_CYC; t++) begin
            expect_obs(b + len + 1 + s * (ON_CYC + OFF_CYC) + t, 0,
                       (t < ON_CYC) ? {8'd0, oh(pat(b, s))} : 16'd0);
         end
      end
      in_c = b + len * (1 + ON_CYC + OFF_CYC) + 1;
      expect_obs(in_c - 1, 2, 16'd0);
      expect_obs(in_c, 2, 16'd1);
   endtask

   task automatic win_round(input int b, input int len, input int in_c,
                            input logic [4:0] rc, input logic [4:0] sc, output int j);
      expect_ev(in_c + len, K_WIN, rc, sc);
      for (int i = 0; i < len; i++) press(in_c + i, oh(pat(b, i)));
      j = in_c + len;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d required completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int b, in_c, j, c;
      rst = 1'b0; start = 1'b0; level = 3'b001; btn = 8'd0;
      for (int s = 0; s < 6; s++) expect_obs(3, s, 16'd0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Game 1, level 1 (L=4): win with ignored early presses, two-bit lose, win.
      start_game(3'b001, b);
      show_round(b, 4, in_c);
      press(b + 4 + 2, oh(pat(b, 0)));
      press(in_c - 1, oh(pat(b, 0)));
      win_round(b, 4, in_c, 5'd1, 5'd1, j);

      b = j + GAP_CYC;
      show_round(b, 4, in_c);
      expect_ev(in_c + 2, K_LOSE, 5'd2, 5'd1);
      press(in_c, oh(pat(b, 0)));
      press(in_c + 1, oh(pat(b, 1)) | oh(pat(b, 1) + 3'd1));
      j = in_c + 2;

      b = j + GAP_CYC;
      show_round(b, 4, in_c);
      expect_obs(in_c + 4, 1, 16'd1);
      win_round(b, 4, in_c, 5'd3, 5'd2, j);
      expect_obs(j + 1, 3, 16'd1);
      expect_obs(j + 1, 1, 16'd0);
      expect_obs(j + 1, 0, 16'd0);
      expect_obs(j + 5, 4, 16'd3);
      expect_obs(j + 5, 5, 16'd2);
      wait_cyc(j + 6);

      // Game 2 from DONE, level 3 (L=16): wrong 8th press, restarted timeout, timeout.
      start_game(3'b100, b);
      expect_obs(b + 2, 4, 16'd0);
      expect_obs(b + 2, 5, 16'd0);
      expect_obs(b + 2, 3, 16'd0);
      show_round(b, 16, in_c);
      expect_ev(in_c + 8, K_LOSE, 5'd1, 5'd0);
      for (int i = 0; i < 7; i++) press(in_c + i, oh(pat(b, i)));
      press(in_c + 7, oh(pat(b, 7) + 3'd1));
      j = in_c + 8;

      b = j + GAP_CYC;
      show_round(b, 16, in_c);
      expect_ev(in_c + 2 * TIMEOUT_CYC, K_LOSE, 5'd2, 5'd0);
      expect_obs(in_c + TIMEOUT_CYC, 2, 16'd1);
      expect_obs(in_c + 2 * TIMEOUT_CYC - 1, 2, 16'd1);
      press(in_c + TIMEOUT_CYC - 1, oh(pat(b, 0)));
      j = in_c + 2 * TIMEOUT_CYC;

      b = j + GAP_CYC;
      show_round(b, 16, in_c);
      expect_ev(in_c + TIMEOUT_CYC, K_LOSE, 5'd3, 5'd0);
      expect_obs(in_c + TIMEOUT_CYC - 1, 2, 16'd1);
      expect_obs(in_c + TIMEOUT_CYC + 1, 3, 16'd1);
      j = in_c + TIMEOUT_CYC;
      wait_cyc(j + 2);

      // Invalid level in DONE: error pulse, stays in DONE.
      expect_ev(cyc + 1, K_LERR, 5'd3, 5'd0);
      start_game(3'b011, c);
      expect_obs(c + 2, 1, 16'd0);
      expect_obs(c + 2, 3, 16'd1);
      wait_cyc(c + 4);

      // Game 3, level 2 (L=8): reset during playback.
      start_game(3'b010, b);
      wait_cyc(b + 8);
      expect_obs(b + 8 + 2, 0, {8'd0, oh(pat(b, 0))});
      wait_cyc(b + 8 + 3);
      for (int s = 0; s < 6; s++) expect_obs(b + 8 + 4, s, 16'd0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Invalid level in IDLE: error pulse, stays idle.
      expect_ev(cyc + 1, K_LERR, 5'd0, 5'd0);
      start_game(3'b011, c);
      expect_obs(c + 2, 1, 16'd0);
      expect_obs(c + 2, 3, 16'd0);

      for (int k = 0; k < 50; k++) begin
         if (obs_q.size() == 0 && ev_q.size() == 0 && !pend) break;
         @(negedge clk);
      end
      if (obs_q.size() != 0 || ev_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL leftover obs=%0d events=%0d required 0/0", obs_q.size(), ev_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
